mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_starve_counter.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, state/owner encodings and starvation default
//
// Purpose: common definitions for the instruction/data port arbiter in front of
// a single-port RAM. Imported by mem_port_arbiter and arb_starve_counter.
// Contents: PC/GPR/instruction widths, FSM state encoding, owner encoding,
// default starvation limit.
package mem_port_arbiter_pkg;

  localparam int PC_WIDTH          = 32;
  localparam int GPR_WIDTH         = 32;
  localparam int INSTRUCTION_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ACC  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF  = 1'b0,
    ARB_OWN_MEM = 1'b1
  } arb_owner_e;

  localparam int ARB_STARVE_LIMIT = 3;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of data grants made over a waiting fetch
//
// Purpose: counts MEM grants issued while a fetch is pending; flags when the
// count reaches LIMIT so the next arbitration can hand the port to IF.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   mem_grant   a MEM grant is being made this cycle
//   if_grant    an IF grant is being made this cycle
//   if_req      fetch request level at the arbitration point
//   limit_hit   counter equals LIMIT
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = ARB_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_grant,
  input  logic if_grant,
  input  logic if_req,
  output logic limit_hit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_grant) begin
      cnt_d = '0;
    end else if (mem_grant) begin
      if (if_req) begin
        // Saturate so a long data burst cannot wrap the count back under LIMIT.
        if (cnt_q != LIMIT_C) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign limit_hit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one shared single-port RAM
//
// Purpose: three-state FSM (IDLE, ACC, RESP) granting the RAM to the fetch or
// data port, one access per two cycles back to back. MEM wins ties.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive MEM grants
// made while if_req is high, the next arbitration goes to IF.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   if_req, if_addr                   fetch request/address
//   if_rdata, if_ready                fetched instruction, completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                         data request, direction, address, write data
//   mem_rdata, mem_ready              read data, completion pulse
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata              RAM port (read data one cycle after ram_en)
//   arb_busy                          FSM not in IDLE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_req,
  input  logic [PC_WIDTH-1:0]          if_addr,
  output logic [INSTRUCTION_WIDTH-1:0] if_rdata,
  output logic                         if_ready,
  input  logic                         mem_req,
  input  logic                         mem_we,
  input  logic [GPR_WIDTH-1:0]         mem_addr,
  input  logic [GPR_WIDTH-1:0]         mem_wdata,
  output logic [GPR_WIDTH-1:0]         mem_rdata,
  output logic                         mem_ready,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [31:0]                  ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata,
  output logic                         arb_busy
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;

  logic arb_slot;
  logic grant_mem;
  logic grant_if;
  logic starve_force;

  // Arbitration happens both from IDLE and from RESP so back-to-back
  // requests reach ACC without an idle bubble.
  assign arb_slot  = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
  assign grant_mem = arb_slot && mem_req && !(starve_force && if_req);
  assign grant_if  = arb_slot && if_req && !grant_mem;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .mem_grant(grant_mem),
    .if_grant (grant_if),
    .if_req   (if_req),
    .limit_hit(starve_force)
  );
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      ARB_ACC: state_d = ARB_RESP;
      ARB_IDLE, ARB_RESP: begin
        if (grant_mem) begin
          state_d = ARB_ACC;
          owner_d = ARB_OWN_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_we;
        end else if (grant_if) begin
          state_d = ARB_ACC;
          owner_d = ARB_OWN_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // All RAM-side and response outputs are gated by state, so the async reset
  // forcing IDLE silences them immediately, even mid-access.
  logic in_acc;
  logic in_resp;
  assign in_acc  = (state_q == ARB_ACC);
  assign in_resp = (state_q == ARB_RESP);

  assign ram_en    = in_acc;
  assign ram_we    = in_acc && we_q && (owner_q == ARB_OWN_MEM);
  assign ram_addr  = in_acc ? addr_q  : 32'd0;
  assign ram_wdata = in_acc ? wdata_q : 32'd0;

  assign if_ready  = in_resp && (owner_q == ARB_OWN_IF);
  assign mem_ready = in_resp && (owner_q == ARB_OWN_MEM);
  assign if_rdata  = if_ready  ? ram_rdata : '0;
  assign mem_rdata = mem_ready ? ram_rdata : '0;

  assign arb_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        arb_busy;

  int total;
  int bad;

  mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .arb_busy (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, plus a bench-only preload port.
  logic [31:0] ram [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    if (ram_en) begin
      ram_rdata <= ram[ram_addr[7:0]];
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h44; mem_wdata = 32'hFFFF_FFFF;
    tick();
    tick();
    total++; if (ram_en !== 1'b0)      begin bad++; $display("FAIL reset_ram_en got=%b want=0", ram_en); end
    total++; if (ram_we !== 1'b0)      begin bad++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
    total++; if (ram_addr !== 32'd0)   begin bad++; $display("FAIL reset_ram_addr got=%h want=0", ram_addr); end
    total++; if (ram_wdata !== 32'd0)  begin bad++; $display("FAIL reset_ram_wdata got=%h want=0", ram_wdata); end
    total++; if (if_ready !== 1'b0)    begin bad++; $display("FAIL reset_if_ready got=%b want=0", if_ready); end
    total++; if (mem_ready !== 1'b0)   begin bad++; $display("FAIL reset_mem_ready got=%b want=0", mem_ready); end
    total++; if (if_rdata !== 32'd0)   begin bad++; $display("FAIL reset_if_rdata got=%h want=0", if_rdata); end
    total++; if (mem_rdata !== 32'd0)  begin bad++; $display("FAIL reset_mem_rdata got=%h want=0", mem_rdata); end
    total++; if (arb_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", arb_busy); end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (arb_busy !== 1'b0)    begin bad++; $display("FAIL post_reset_idle got=%b want=0", arb_busy); end
  endtask

  task automatic test_single_fetch;
    preload(8'h10, 32'hDEAD_BEEF);
    if_req = 1'b1; if_addr = 32'h10;
    mem_we = 1'b1;  // stray level on the idle data port must not leak into a fetch
    tick();
    total++; if (ram_en !== 1'b1)      begin bad++; $display("FAIL fetch_ram_en got=%b want=1", ram_en); end
    total++; if (ram_addr !== 32'h10)  begin bad++; $display("FAIL fetch_ram_addr got=%h want=10", ram_addr); end
    total++; if (ram_we !== 1'b0)      begin bad++; $display("FAIL fetch_ram_we got=%b want=0", ram_we); end
    total++; if (if_ready !== 1'b0)    begin bad++; $display("FAIL fetch_early_ready got=%b want=0", if_ready); end
    tick();
    total++; if (if_ready !== 1'b1)    begin bad++; $display("FAIL fetch_ready got=%b want=1", if_ready); end
    total++; if (if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", if_rdata); end
    total++; if (mem_ready !== 1'b0)   begin bad++; $display("FAIL fetch_mem_ready got=%b want=0", mem_ready); end
    total++; if (mem_rdata !== 32'd0)  begin bad++; $display("FAIL fetch_mem_rdata got=%h want=0", mem_rdata); end
    if_req = 1'b0; mem_we = 1'b0;
    tick();
    total++; if (arb_busy !== 1'b0)    begin bad++; $display("FAIL fetch_busy_after got=%b want=0", arb_busy); end
    total++; if (if_rdata !== 32'd0)   begin bad++; $display("FAIL fetch_rdata_after got=%h want=0", if_rdata); end
  endtask

  task automatic test_back_to_back;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1234_5678;
    tick();
    total++; if (ram_we !== 1'b1)      begin bad++; $display("FAIL wr_ram_we got=%b want=1", ram_we); end
    total++; if (ram_addr !== 32'h40)  begin bad++; $display("FAIL wr_ram_addr got=%h want=40", ram_addr); end
    total++; if (ram_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_ram_wdata got=%h want=12345678", ram_wdata); end
    tick();
    total++; if (mem_ready !== 1'b1)   begin bad++; $display("FAIL wr_ready got=%b want=1", mem_ready); end
    // Request stays high through ready: taken as the follow-up read.
    mem_we = 1'b0; mem_wdata = 32'hFFFF_0000;
    tick();
    total++; if (ram_en !== 1'b1)      begin bad++; $display("FAIL rd_ram_en got=%b want=1", ram_en); end
    total++; if (ram_we !== 1'b0)      begin bad++; $display("FAIL rd_ram_we got=%b want=0", ram_we); end
    total++; if (mem_ready !== 1'b0)   begin bad++; $display("FAIL rd_ready_gap got=%b want=0", mem_ready); end
    tick();
    total++; if (mem_ready !== 1'b1)   begin bad++; $display("FAIL rd_ready got=%b want=1", mem_ready); end
    total++; if (mem_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata got=%h want=12345678", mem_rdata); end
    mem_req = 1'b0;
    tick();
    total++; if (arb_busy !== 1'b0)    begin bad++; $display("FAIL rd_busy_after got=%b want=0", arb_busy); end
  endtask

  task automatic test_collision;
    preload(8'h20, 32'hCAFE_F00D);
    preload(8'h30, 32'h0BAD_F00D);
    if_req = 1'b1; if_addr = 32'h20;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30;
    tick();
    total++; if (ram_addr !== 32'h30)  begin bad++; $display("FAIL col_first_addr got=%h want=30", ram_addr); end
    tick();
    total++; if (mem_ready !== 1'b1)   begin bad++; $display("FAIL col_mem_ready got=%b want=1", mem_ready); end
    total++; if (if_ready !== 1'b0)    begin bad++; $display("FAIL col_if_not_ready got=%b want=0", if_ready); end
    total++; if (mem_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL col_mem_rdata got=%h want=0badf00d", mem_rdata); end
    total++; if (if_rdata !== 32'd0)   begin bad++; $display("FAIL col_if_rdata_zero got=%h want=0", if_rdata); end
    mem_req = 1'b0;
    tick();
    total++; if (ram_addr !== 32'h20)  begin bad++; $display("FAIL col_second_addr got=%h want=20", ram_addr); end
    tick();
    total++; if (if_ready !== 1'b1)    begin bad++; $display("FAIL col_if_ready got=%b want=1", if_ready); end
    total++; if (if_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL col_if_rdata got=%h want=cafef00d", if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation;
    logic exp_if;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h20;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30;
    for (int k = 0; k < 8; k++) begin
      tick();
      tick();
`ifdef ARB_STARVE_GUARD_EN
      exp_if = ((k % 4) == 3);
`else
      exp_if = 1'b0;
`endif
      total++;
      if (if_ready !== exp_if || mem_ready !== !exp_if) begin
        bad++;
        $display("FAIL starve_grant_%0d got if=%b mem=%b want if=%b mem=%b", k, if_ready, mem_ready, exp_if, !exp_if);
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access;
    preload(8'h80, 32'hA5A5_A5A5);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1111_2222;
    tick();
    total++; if (ram_en !== 1'b1)      begin bad++; $display("FAIL rstmid_in_acc got=%b want=1", ram_en); end
    rst = 1'b0;
    #1;
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL rstmid_ram_strobes got en=%b we=%b want 0 0", ram_en, ram_we); end
    total++; if (ram_addr !== 32'd0 || ram_wdata !== 32'd0) begin bad++; $display("FAIL rstmid_ram_bus got addr=%h wdata=%h want 0 0", ram_addr, ram_wdata); end
    total++; if (arb_busy !== 1'b0)    begin bad++; $display("FAIL rstmid_busy got=%b want=0", arb_busy); end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    total++; if (mem_ready !== 1'b0)   begin bad++; $display("FAIL rstmid_no_ready got=%b want=0", mem_ready); end
    tick();
    total++; if (ram[8'h80] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL rstmid_ram_kept got=%h want=a5a5a5a5", ram[8'h80]); end
    rst = 1'b1;
    tick();
    total++; if (mem_ready !== 1'b0 || arb_busy !== 1'b0) begin bad++; $display("FAIL rstmid_after got ready=%b busy=%b want 0 0", mem_ready, arb_busy); end
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    total++; if (ram_en !== 1'b1)      begin bad++; $display("FAIL rstmid_first_arb got=%b want=1", ram_en); end
    tick();
    total++; if (if_ready !== 1'b1)    begin bad++; $display("FAIL rstmid_first_ready got=%b want=1", if_ready); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_during_acc;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    if_req = 1'b0; if_addr = 32'h20;  // later changes must not touch the in-flight fetch
    total++; if (ram_addr !== 32'h10)  begin bad++; $display("FAIL drop_addr_latched got=%h want=10", ram_addr); end
    tick();
    total++; if (if_ready !== 1'b1)    begin bad++; $display("FAIL drop_ready got=%b want=1", if_ready); end
    total++; if (if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL drop_rdata got=%h want=deadbeef", if_rdata); end
    tick();
    total++; if (ram_en !== 1'b0 || arb_busy !== 1'b0) begin bad++; $display("FAIL drop_no_second got en=%b busy=%b want 0 0", ram_en, arb_busy); end
    tick();
    total++; if (ram_en !== 1'b0 || if_ready !== 1'b0) begin bad++; $display("FAIL drop_quiet got en=%b ready=%b want 0 0", ram_en, if_ready); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_collision();
    test_starvation();
    test_reset_mid_access();
    test_drop_during_acc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
